// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM state encoding plus the opcode and
// bubble constants used by fetch and decode.
package pipeline_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2,
        HALTED  = 2'd3
    } fetch_state_t;

    localparam logic [3:0]  OPC_HLT   = 4'hF;
    localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer for an instruction word returned while decode stalls.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   load, load_data    capture a word (sets full)
//   clear              drop contents (highest priority)
//   take               consume contents (clears full)
//   data, full         buffered word and occupancy flag
module fetch_skid_buffer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_data,
    input  logic        clear,
    input  logic        take,
    output logic [15:0] data,
    output logic        full
);

    logic [15:0] data_q, data_d;
    logic        full_q, full_d;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (clear) begin
            full_d = 1'b0;
        end else if (load) begin
            data_d = load_data;
            full_d = 1'b1;
        end else if (take) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign data = data_q;
    assign full = full_q;

endmodule

// File: rtl/fetch_decode_stage.sv
// Fetch stage: owns the PC, issues requests to a multi-cycle instruction
// memory and holds the fetched word plus PC+2 in the IF/ID register.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   stall                    hold IF/ID and PC (load-use hazard)
//   flush, branch_target     squash IF/ID and redirect the PC
//   imem_req, imem_addr      fetch request / address (addr == pc)
//   imem_rdata, imem_valid   memory response
//   ifid_instr, ifid_pc_plus2, ifid_valid   IF/ID register
//   pc                       current fetch PC
//   halted                   fetch stopped on HLT
module fetch_decode_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [3:0]  HALT_OPC  = pipeline_pkg::OPC_HLT,
    parameter logic [15:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
    output logic [15:0] pc,
    output logic        halted
);

    import pipeline_pkg::*;

    fetch_state_t state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  ifid_instr_q, ifid_instr_d;
    logic [15:0]  ifid_pc_plus2_q, ifid_pc_plus2_d;
    logic         ifid_valid_q, ifid_valid_d;
    logic         halted_q, halted_d;

    logic [15:0]  pc_plus2;
    logic         cap_en;
    logic [15:0]  cap_word;
    logic         skid_load, skid_clear, skid_take;
    logic [15:0]  skid_data;
    logic         skid_full;

    assign pc_plus2 = pc_q + 16'd2;

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        ifid_instr_d    = ifid_instr_q;
        ifid_pc_plus2_d = ifid_pc_plus2_q;
        ifid_valid_d    = ifid_valid_q;
        cap_en          = 1'b0;
        cap_word        = imem_rdata;
        skid_load       = 1'b0;
        skid_clear      = 1'b0;
        skid_take       = 1'b0;

        if (flush) begin
            pc_d         = {branch_target[15:1], 1'b0};
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            skid_clear   = 1'b1;
            // A request still in flight (including a stale one already being
            // discarded) must have its response dropped before refetching.
            if ((state_q == FETCH || state_q == DISCARD) && !imem_valid)
                state_d = DISCARD;
            else
                state_d = FETCH;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem_valid && !stall) begin
                        cap_en = 1'b1;
                    end else if (imem_valid && stall) begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end else if (!stall) begin
                        ifid_valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        cap_en    = 1'b1;
                        cap_word  = skid_data;
                        skid_take = 1'b1;
                    end
                end
                DISCARD: begin
                    if (imem_valid)
                        state_d = FETCH;
                end
                HALTED: begin
                    if (!stall)
                        ifid_valid_d = 1'b0;
                end
            endcase
        end

        // Shared capture path for a fresh response or a drained skid entry.
        if (cap_en) begin
            ifid_instr_d    = cap_word;
            ifid_pc_plus2_d = pc_plus2;
            ifid_valid_d    = 1'b1;
            if (cap_word[15:12] == HALT_OPC) begin
                state_d = HALTED;
            end else begin
                pc_d    = pc_plus2;
                state_d = FETCH;
            end
        end

        halted_d = (state_d == HALTED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= FETCH;
            pc_q            <= {RESET_PC[15:1], 1'b0};
            ifid_instr_q    <= NOP_INSTR;
            ifid_pc_plus2_q <= '0;
            ifid_valid_q    <= 1'b0;
            halted_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_pc_plus2_q <= ifid_pc_plus2_d;
            ifid_valid_q    <= ifid_valid_d;
            halted_q        <= halted_d;
        end
    end

    fetch_skid_buffer u_skid (
        .clk       (clk),
        .rst_n     (rst),
        .load      (skid_load),
        .load_data (imem_rdata),
        .clear     (skid_clear),
        .take      (skid_take),
        .data      (skid_data),
        .full      (skid_full)
    );

    // Occupancy is implied by the HOLD state; the flag is kept for debug.
    logic skid_full_unused;
    assign skid_full_unused = skid_full;

    assign imem_req      = (state_q == FETCH) || (state_q == DISCARD);
    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign ifid_instr    = ifid_instr_q;
    assign ifid_pc_plus2 = ifid_pc_plus2_q;
    assign ifid_valid    = ifid_valid_q;
    assign halted        = halted_q;

endmodule

// File: tb/tb_fetch_decode_stage.sv
module tb_fetch_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [15:0] branch_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic [15:0] pc;
    logic        halted;

    always #5 clk = ~clk;

    fetch_decode_stage #(
        .RESET_PC  (16'h0000),
        .HALT_OPC  (4'hF),
        .NOP_INSTR (16'h0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus2 (ifid_pc_plus2),
        .ifid_valid    (ifid_valid),
        .pc            (pc),
        .halted        (halted)
    );

    typedef struct {
        logic        stall;
        logic        flush;
        logic [15:0] bt;
        logic        valid;
        logic [15:0] rdata;
        logic        e_req;
        logic [15:0] e_pc;
        logic [15:0] e_instr;
        logic [15:0] e_pp2;
        logic        chk_pp2;
        logic        e_ival;
        logic        e_halt;
    } vec_t;

    vec_t vecs [0:27];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic s, input logic f, input logic [15:0] bt,
                                input logic v, input logic [15:0] rd,
                                input logic er, input logic [15:0] ep,
                                input logic [15:0] ei, input logic [15:0] epp,
                                input logic cp, input logic ev, input logic eh);
        vec_t r;
        r.stall = s;  r.flush = f;  r.bt = bt;  r.valid = v;  r.rdata = rd;
        r.e_req = er; r.e_pc = ep;  r.e_instr = ei; r.e_pp2 = epp;
        r.chk_pp2 = cp; r.e_ival = ev; r.e_halt = eh;
        return r;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic f, input logic [15:0] bt,
                         input logic v, input logic [15:0] rd);
        stall = s; flush = f; branch_target = bt; imem_valid = v; imem_rdata = rd;
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].bt, vecs[i].valid, vecs[i].rdata);
            @(posedge clk);
            #1;
            chk("imem_req",   i, {15'd0, imem_req},   {15'd0, vecs[i].e_req});
            chk("imem_addr",  i, imem_addr,           vecs[i].e_pc);
            chk("pc",         i, pc,                  vecs[i].e_pc);
            chk("ifid_instr", i, ifid_instr,          vecs[i].e_instr);
            if (vecs[i].chk_pp2)
                chk("ifid_pc_plus2", i, ifid_pc_plus2, vecs[i].e_pp2);
            chk("ifid_valid", i, {15'd0, ifid_valid}, {15'd0, vecs[i].e_ival});
            chk("halted",     i, {15'd0, halted},     {15'd0, vecs[i].e_halt});
        end
    endtask

    task automatic chk_reset(input int tag);
        chk("rst_pc",    tag, pc,                    16'h0000);
        chk("rst_addr",  tag, imem_addr,             16'h0000);
        chk("rst_req",   tag, {15'd0, imem_req},     16'h0001);
        chk("rst_instr", tag, ifid_instr,            16'h0000);
        chk("rst_pp2",   tag, ifid_pc_plus2,         16'h0000);
        chk("rst_ival",  tag, {15'd0, ifid_valid},   16'h0000);
        chk("rst_halt",  tag, {15'd0, halted},       16'h0000);
    endtask

    initial begin
        //               s  f  bt        v  rdata     req pc        instr     pp2     cp ival halt
        // 1-cycle memory from reset
        vecs[0]  = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0);
        vecs[1]  = mk(0, 0, 16'h0000, 1, 16'h1111, 1, 16'h0002, 16'h1111, 16'h0002, 1, 1, 0);
        vecs[2]  = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 16'h1111, 16'h0002, 1, 0, 0);
        vecs[3]  = mk(0, 0, 16'h0000, 1, 16'h2222, 1, 16'h0004, 16'h2222, 16'h0004, 1, 1, 0);
        vecs[4]  = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 16'h2222, 16'h0004, 1, 0, 0);
        vecs[5]  = mk(0, 0, 16'h0000, 1, 16'h3333, 1, 16'h0006, 16'h3333, 16'h0006, 1, 1, 0);
        // flush with same-cycle response: response dropped, redirect to 0x000E
        vecs[6]  = mk(0, 1, 16'h000E, 1, 16'h4444, 1, 16'h000E, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[7]  = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h000E, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[8]  = mk(0, 0, 16'h0000, 1, 16'h5555, 1, 16'h0010, 16'h5555, 16'h0010, 1, 1, 0);
        // stall on response 0x1234 at pc 0x0010, held three cycles
        vecs[9]  = mk(1, 0, 16'h0000, 1, 16'h1234, 0, 16'h0010, 16'h5555, 16'h0010, 1, 1, 0);
        vecs[10] = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0010, 16'h5555, 16'h0010, 1, 1, 0);
        vecs[11] = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0010, 16'h5555, 16'h0010, 1, 1, 0);
        vecs[12] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0012, 16'h1234, 16'h0012, 1, 1, 0);
        // flush to 0x0100 with request outstanding; stale 0xAAAA two cycles later
        vecs[13] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0012, 16'h1234, 16'h0012, 1, 0, 0);
        vecs[14] = mk(0, 1, 16'h0100, 0, 16'h0000, 1, 16'h0100, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[15] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0100, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[16] = mk(0, 0, 16'h0000, 1, 16'hAAAA, 1, 16'h0100, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[17] = mk(0, 0, 16'h0000, 1, 16'h6666, 1, 16'h0102, 16'h6666, 16'h0102, 1, 1, 0);
        // flush and stall together: stall ignored
        vecs[18] = mk(1, 1, 16'h0200, 0, 16'h0000, 1, 16'h0200, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[19] = mk(0, 0, 16'h0000, 1, 16'hBBBB, 1, 16'h0200, 16'h0000, 16'h0000, 0, 0, 0);
        // HLT fetched at 0x0020
        vecs[20] = mk(0, 1, 16'h0020, 1, 16'hCCCC, 1, 16'h0020, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[21] = mk(0, 0, 16'h0000, 1, 16'hF000, 0, 16'h0020, 16'hF000, 16'h0022, 1, 1, 1);
        // resume from HALTED via flush to 0x0040
        vecs[22] = mk(0, 1, 16'h0040, 0, 16'h0000, 1, 16'h0040, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[23] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0040, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[24] = mk(0, 0, 16'h0000, 1, 16'h7777, 1, 16'h0042, 16'h7777, 16'h0042, 1, 1, 0);
        // PC wrap at 0xFFFE
        vecs[25] = mk(0, 1, 16'hFFFE, 1, 16'h9999, 1, 16'hFFFE, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[26] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'hFFFE, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[27] = mk(0, 0, 16'h0000, 1, 16'h8888, 1, 16'h0000, 16'h8888, 16'h0000, 1, 1, 0);

        rst = 1'b0;
        drive(0, 0, 16'h0000, 0, 16'h0000);
        #2;
        chk_reset(0);
        #10;
        rst = 1'b1;

        run(0, 21);

        // HALTED: no requests for 10 cycles, IF/ID turns into a bubble
        for (int c = 0; c < 10; c++) begin
            drive(0, 0, 16'h0000, 0, 16'h0000);
            @(posedge clk);
            #1;
            chk("halt_req",   c, {15'd0, imem_req},   16'h0000);
            chk("halt_flag",  c, {15'd0, halted},     16'h0001);
            chk("halt_pc",    c, pc,                  16'h0020);
            chk("halt_ival",  c, {15'd0, ifid_valid}, 16'h0000);
        end

        run(22, 27);

        // asynchronous reset mid-fetch, well away from a clock edge
        drive(0, 0, 16'h0000, 0, 16'h0000);
        #2;
        rst = 1'b0;
        #1;
        chk_reset(1);
        #20;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_req",  0, {15'd0, imem_req},   16'h0001);
        chk("post_rst_addr", 0, imem_addr,           16'h0000);
        chk("post_rst_ival", 0, {15'd0, ifid_valid}, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
